upsample2x: RTL and testbench

Nearest-neighbour 2x2 upsampler for the CNN datapath. It consumes a pooled feature-map stream of `pooldata_num` x `pooldata_num` signed 22-bit pixels in raster order. It emits the matching `2*pooldata_num` x `2*pooldata_num` stream, in which each input pixel fills a 2x2 output block. It is the inverse-direction companion of the maxpool stage and feeds decoder / reconstruction layers. A one-row buffer replays each input row, and an input ready throttles the upstream source to the 4x output rate.

---
 rtl/upsample2x.sv | 128 ++++++++++++
 tb/tb_upsample2x.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample2x.sv
// upsample2x: nearest-neighbour 2x2 upsampler for the CNN decoder path.
// Each pooled input pixel becomes a 2x2 block of output pixels. Output row
// 2r is produced while row r streams in (each pixel emitted twice), then a
// one-row buffer replays row r to form output row 2r+1.
// Optional build macro UPSAMPLE_ZERO_FILL_EN switches to zero-fill
// unpooling: only the top-left pixel of each 2x2 block carries data and the
// other three positions are 0, with identical handshake and timing.
module upsample2x #(
    parameter int pooldata_num = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pool_valid,
    output logic               pool_ready,
    input  logic signed [21:0] pool_data,
    output logic               up_valid,
    output logic signed [21:0] up_data,
    output logic               up_last
);

    localparam int CW = (pooldata_num > 1) ? $clog2(pooldata_num) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(pooldata_num - 1);

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        REPLAY = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          rep;
    logic          accept;

    assign accept = pool_valid && pool_ready;

`ifndef UPSAMPLE_ZERO_FILL_EN
    logic signed [21:0] row_buf [pooldata_num];

    // Capture each accepted pixel so the row can be replayed as the odd output row
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[col] <= pool_data;
        end
    end
`endif

    // Sequencer: fill half-row with horizontal duplicates, then replay the row
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FILL_A;
            col        <= '0;
            row        <= '0;
            rep        <= 1'b0;
            pool_ready <= 1'b1;
            up_valid   <= 1'b0;
            up_data    <= '0;
            up_last    <= 1'b0;
        end else begin
            up_last <= 1'b0;
            case (state)
                FILL_A: begin
                    if (accept) begin
                        up_valid   <= 1'b1;
                        up_data    <= pool_data;
                        pool_ready <= 1'b0;
                        state      <= FILL_B;
                    end else begin
                        up_valid <= 1'b0;
                    end
                end

                FILL_B: begin
                    up_valid <= 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
                    up_data  <= '0;
`endif
                    if (col == LAST_IDX) begin
                        col        <= '0;
                        rep        <= 1'b0;
                        pool_ready <= 1'b0;
                        state      <= REPLAY;
                    end else begin
                        col        <= col + 1'b1;
                        pool_ready <= 1'b1;
                        state      <= FILL_A;
                    end
                end

                REPLAY: begin
                    up_valid <= 1'b1;
`ifdef UPSAMPLE_ZERO_FILL_EN
                    up_data  <= '0;
`else
                    up_data  <= row_buf[col];
`endif
                    rep <= ~rep;
                    if (rep) begin
                        if (col == LAST_IDX) begin
                            col        <= '0;
                            pool_ready <= 1'b1;
                            state      <= FILL_A;
                            if (row == LAST_IDX) begin
                                row     <= '0;
                                up_last <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= FILL_A;
                    col        <= '0;
                    row        <= '0;
                    rep        <= 1'b0;
                    pool_ready <= 1'b1;
                    up_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2x.sv
// Testbench for upsample2x. Stimulus drives pooled frames; every accepted
// pixel releases whichever output positions (y,x) whose source pixel
// (y/2, x/2) is now known, and those are queued for an independent monitor.
module tb_upsample2x;

    localparam int N = 14;
    localparam int OUT_PER_FRAME = 4 * N * N;
`ifdef UPSAMPLE_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    logic               clk;
    logic               rstn;
    logic               pool_valid;
    logic               pool_ready;
    logic signed [21:0] pool_data;
    logic               up_valid;
    logic signed [21:0] up_data;
    logic               up_last;

    typedef struct {
        logic signed [21:0] data;
        logic               last;
    } exp_t;

    exp_t               sb[$];
    logic signed [21:0] in_frame [N*N];
    int                 k;
    int                 out_idx;
    int                 vectors;
    int                 miscompares;
    int                 run_len;
    bit                 cont_check;
    logic signed [21:0] exp_hold;

    upsample2x #(.pooldata_num(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pool_valid (pool_valid),
        .pool_ready (pool_ready),
        .pool_data  (pool_data),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_last    (up_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard so a stuck design cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: output (y,x) is input (y/2,x/2); zero-fill keeps only even/even
    function automatic logic signed [21:0] model_pixel(input int y, input int x);
        if (ZERO_FILL && (((y % 2) != 0) || ((x % 2) != 0)))
            return '0;
        return in_frame[(y / 2) * N + (x / 2)];
    endfunction

    // Queue every not-yet-queued output position whose source pixel is known
    task automatic push_outputs(input int src_max);
        int y;
        int x;
        exp_t e;
        while (out_idx < OUT_PER_FRAME) begin
            y = out_idx / (2 * N);
            x = out_idx % (2 * N);
            if ((y / 2) * N + (x / 2) > src_max)
                break;
            e.data = model_pixel(y, x);
            e.last = (out_idx == OUT_PER_FRAME - 1);
            sb.push_back(e);
            out_idx++;
        end
    endtask

    task automatic record_accept(input logic signed [21:0] d);
        in_frame[k] = d;
        push_outputs(k);
        k++;
        if (k == N * N) begin
            k = 0;
            out_idx = 0;
        end
    endtask

    function automatic logic signed [21:0] gen_pixel(input int dmode, input int idx);
        logic signed [21:0] v;
        case (dmode)
            0:       v = 22'(idx);
            1:       v = 22'($urandom);
            default: v = (idx % 2 == 0) ? 22'h200000 : 22'h1FFFFF;
        endcase
        return v;
    endfunction

    // Offer pixels with the given valid duty (percent) until count are accepted;
    // called just after a rising edge
    task automatic apply_stimulus(input int count, input int duty, input int dmode);
        int got = 0;
        int cycles = 0;
        int low_left = -1;
        while (got < count) begin
            if (cycles > count * 60 + 200) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL accept_timeout: got %0d accepted required %0d", got, count);
                break;
            end
            pool_valid = ($urandom_range(99) < duty);
            pool_data  = gen_pixel(dmode, k);
            @(negedge clk);
            if (low_left > 0) begin
                check_output("ready_low", {31'b0, pool_ready}, 32'd0);
                low_left--;
            end else if (low_left == 0) begin
                check_output("ready_high", {31'b0, pool_ready}, 32'd1);
                low_left = -1;
            end
            if (pool_valid && pool_ready && rstn) begin
                low_left = ((k % N) == N - 1) ? 2 * N + 1 : 1;
                record_accept(pool_data);
                got++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        pool_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        pool_valid = 1'b0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d outputs outstanding required 0", sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every valid output against the queue; idle cycles hold data
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            run_len  = 0;
            exp_hold = '0;
        end else if (up_valid) begin
            run_len++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_output: got data %0h required no output", up_data);
            end else begin
                e = sb.pop_front();
                exp_hold = e.data;
                check_output("up_data", 32'(up_data), 32'(e.data));
                check_output("up_last", {31'b0, up_last}, {31'b0, e.last});
            end
            if (up_last) begin
                if (cont_check) begin
                    check_output("frame_valid_run", 32'(run_len), 32'(OUT_PER_FRAME));
                    cont_check = 1'b0;
                end
                run_len = 0;
            end
        end else begin
            run_len = 0;
            check_output("idle_last", {31'b0, up_last}, 32'd0);
            check_output("idle_hold", 32'(up_data), 32'(exp_hold));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        out_idx     = 0;
        run_len     = 0;
        cont_check  = 1'b0;
        exp_hold    = '0;
        rstn        = 1'b0;
        pool_valid  = 1'b1;
        pool_data   = 22'h5;

        // Reset holds the block idle and ready even with valid asserted
        repeat (2) @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check_output("rst_ready", {31'b0, pool_ready}, 32'd1);
            check_output("rst_valid", {31'b0, up_valid}, 32'd0);
            check_output("rst_data", 32'(up_data), 32'd0);
            check_output("rst_last", {31'b0, up_last}, 32'd0);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;

        $display("[TB] full frame, index data, continuous valid");
        cont_check = 1'b1;
        apply_stimulus(N * N, 100, 0);
        drain();

        $display("[TB] random valid gaps, index then random data");
        apply_stimulus(N * N, 50, 0);
        apply_stimulus(N * N, 50, 1);
        drain();

        $display("[TB] signed extremes, back-to-back frames");
        apply_stimulus(2 * N * N, 100, 2);
        drain();

        $display("[TB] reset after 50 accepted pixels");
        apply_stimulus(50, 100, 0);
        #1;
        rstn = 1'b0;
        sb.delete();
        k       = 0;
        out_idx = 0;
        pool_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("midrst_valid", {31'b0, up_valid}, 32'd0);
            check_output("midrst_data", 32'(up_data), 32'd0);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;
        cont_check = 1'b1;
        apply_stimulus(N * N, 100, 0);
        drain();

        if (cont_check) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_end: got no up_last required one at output %0d", OUT_PER_FRAME);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
